// File: rtl/ifetch_cache_pkg.sv
// Shared types for the instruction-fetch cache: scalar and wrap-index types,
// controller state encoding and a saturating-increment helper.
package defines;

    typedef logic [31:0] scalar_t;

    localparam int NUM_WRAPS_PER_CORE = 4;
    localparam int WRAP_W             = $clog2(NUM_WRAPS_PER_CORE);

    typedef logic [WRAP_W-1:0] wrap_idx_t;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MISS_REQ  = 2'd1,
        ST_MISS_FILL = 2'd2,
        ST_REPLAY    = 2'd3
    } icache_state_t;

    function automatic scalar_t sat_inc(input scalar_t v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ifetch_cache_sram_1r1w.sv
// Synchronous-read, single-write-port memory. A read and a write to the same
// address in one cycle returns the old contents.
module sram_1r1w #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port; output holds when not reading.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ifetch_cache.sv
// Direct-mapped instruction cache with a two-stage hit pipeline and a
// stall-fill-replay miss path. Define ICACHE_STATS_EN to build hit/miss counters.
module ifetch_cache
    import defines::*;
#(
    parameter int NUM_LINES      = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetchReqValid,
    output logic              fetchReqReady,
    input  logic [31:0]       fetchReqPc,
    input  logic [WRAP_W-1:0] fetchReqWrap,
    output logic              fetchRspValid,
    output logic [31:0]       fetchRspInst,
    output logic [31:0]       fetchRspPc,
    output logic [WRAP_W-1:0] fetchRspWrap,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [31:0]       memReqAddr,
    input  logic              memRspValid,
    input  logic [31:0]       memRspData,
    input  logic              invalidate,
    output logic [31:0]       hitCount,
    output logic [31:0]       missCount
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
    localparam int DAW   = IDX_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    icache_state_t        state_q, state_d;
    logic                 s1_valid_q, s1_valid_d;
    scalar_t              s1_pc_q, s1_pc_d;
    logic [WRAP_W-1:0]    s1_wrap_q, s1_wrap_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [OFF_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                 mem_req_valid_q, mem_req_valid_d;
    scalar_t              mem_req_addr_q, mem_req_addr_d;

    logic [IDX_W-1:0] s1_idx_s, req_idx_s, tag_raddr_s;
    logic [OFF_W-1:0] s1_off_s, req_off_s;
    logic [TAG_W-1:0] s1_tag_s, tag_rdata_s;
    logic [DAW-1:0]   data_raddr_s, data_waddr_s;
    scalar_t          data_rdata_s;
    logic             hit_s, rsp_valid_s, miss_s, ready_s, accept_s;
    logic             replay_s, fill_s, last_beat_s, rd_en_s;

    assign s1_off_s  = s1_pc_q[2 +: OFF_W];
    assign s1_idx_s  = s1_pc_q[2 + OFF_W +: IDX_W];
    assign s1_tag_s  = s1_pc_q[31 -: TAG_W];
    assign req_off_s = fetchReqPc[2 +: OFF_W];
    assign req_idx_s = fetchReqPc[2 + OFF_W +: IDX_W];

    // Compare uses the valid bits as they stand before any same-edge invalidate.
    assign hit_s       = s1_valid_q && valid_q[s1_idx_s] && (tag_rdata_s == s1_tag_s);
    assign rsp_valid_s = (state_q == ST_RUN) && hit_s;
    assign miss_s      = (state_q == ST_RUN) && s1_valid_q && !hit_s;
    assign ready_s     = (state_q == ST_RUN) && !miss_s;
    assign accept_s    = fetchReqValid && ready_s;
    assign replay_s    = (state_q == ST_REPLAY);
    assign fill_s      = (state_q == ST_MISS_FILL) && memRspValid;
    assign last_beat_s = fill_s && (beat_cnt_q == LAST_BEAT);

    assign rd_en_s      = accept_s || replay_s;
    assign tag_raddr_s  = replay_s ? s1_idx_s : req_idx_s;
    assign data_raddr_s = replay_s ? {s1_idx_s, s1_off_s} : {req_idx_s, req_off_s};
    assign data_waddr_s = {s1_idx_s, beat_cnt_q};

    sram_1r1w #(.WIDTH(TAG_W), .DEPTH(NUM_LINES)) u_tag_ram (
        .clk   (clk),
        .we    (last_beat_s),
        .waddr (s1_idx_s),
        .wdata (s1_tag_s),
        .re    (rd_en_s),
        .raddr (tag_raddr_s),
        .rdata (tag_rdata_s)
    );

    sram_1r1w #(.WIDTH(32), .DEPTH(NUM_LINES * WORDS_PER_LINE)) u_data_ram (
        .clk   (clk),
        .we    (fill_s),
        .waddr (data_waddr_s),
        .wdata (memRspData),
        .re    (rd_en_s),
        .raddr (data_raddr_s),
        .rdata (data_rdata_s)
    );

    // Controller next-state: S1 capture/hold, miss request, fill beats, replay.
    always_comb begin
        state_d         = state_q;
        s1_valid_d      = s1_valid_q;
        s1_pc_d         = s1_pc_q;
        s1_wrap_d       = s1_wrap_q;
        valid_d         = valid_q;
        beat_cnt_d      = beat_cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        case (state_q)
            ST_RUN: begin
                if (miss_s) begin
                    state_d         = ST_MISS_REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {s1_tag_s, s1_idx_s, {(OFF_W + 2){1'b0}}};
                end else if (accept_s) begin
                    s1_valid_d = 1'b1;
                    s1_pc_d    = fetchReqPc;
                    s1_wrap_d  = fetchReqWrap;
                end else begin
                    s1_valid_d = 1'b0;
                end
            end
            ST_MISS_REQ: begin
                if (memReqReady) begin
                    state_d         = ST_MISS_FILL;
                    mem_req_valid_d = 1'b0;
                    mem_req_addr_d  = 32'd0;
                    beat_cnt_d      = {OFF_W{1'b0}};
                end else begin
                    state_d = ST_MISS_REQ;
                end
            end
            ST_MISS_FILL: begin
                if (last_beat_s) begin
                    state_d           = ST_REPLAY;
                    beat_cnt_d        = {OFF_W{1'b0}};
                    valid_d[s1_idx_s] = 1'b1;
                end else if (fill_s) begin
                    beat_cnt_d = beat_cnt_q + OFF_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            ST_REPLAY: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_RUN;
                s1_valid_d = 1'b0;
            end
        endcase
        valid_d = invalidate ? {NUM_LINES{1'b0}} : valid_d;
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_RUN;
            s1_valid_q      <= 1'b0;
            s1_pc_q         <= 32'd0;
            s1_wrap_q       <= {WRAP_W{1'b0}};
            valid_q         <= {NUM_LINES{1'b0}};
            beat_cnt_q      <= {OFF_W{1'b0}};
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= 32'd0;
        end else begin
            state_q         <= state_d;
            s1_valid_q      <= s1_valid_d;
            s1_pc_q         <= s1_pc_d;
            s1_wrap_q       <= s1_wrap_d;
            valid_q         <= valid_d;
            beat_cnt_q      <= beat_cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
        end
    end

    assign fetchReqReady = ready_s;
    assign fetchRspValid = rsp_valid_s;
    assign fetchRspInst  = rsp_valid_s ? data_rdata_s : 32'd0;
    assign fetchRspPc    = rsp_valid_s ? s1_pc_q : 32'd0;
    assign fetchRspWrap  = rsp_valid_s ? s1_wrap_q : {WRAP_W{1'b0}};
    assign memReqValid   = mem_req_valid_q;
    assign memReqAddr    = mem_req_addr_q;

`ifdef ICACHE_STATS_EN
    scalar_t hit_count_q, hit_count_d;
    scalar_t miss_count_q, miss_count_d;
    logic    replay_q, replay_d;

    // Replayed lookups are excluded from both counters.
    always_comb begin
        replay_d     = replay_s ? 1'b1 : (accept_s ? 1'b0 : replay_q);
        hit_count_d  = (rsp_valid_s && !replay_q) ? sat_inc(hit_count_q) : hit_count_q;
        miss_count_d = (miss_s && !replay_q) ? sat_inc(miss_count_q) : miss_count_q;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            replay_q     <= 1'b0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            replay_q     <= replay_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hitCount  = hit_count_q;
    assign missCount = miss_count_q;
`else
    assign hitCount  = 32'd0;
    assign missCount = 32'd0;
`endif

endmodule

// File: tb/tb_ifetch_cache.sv
// Self-checking bench for ifetch_cache: directed vector table, hand-written
// corner sequences and randomized accesses against a line-level cache model.
module tb_ifetch_cache;
    import defines::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetchReqValid = 1'b0;
    logic        fetchReqReady;
    logic [31:0] fetchReqPc = 32'd0;
    wrap_idx_t   fetchReqWrap = '0;
    logic        fetchRspValid;
    logic [31:0] fetchRspInst;
    logic [31:0] fetchRspPc;
    wrap_idx_t   fetchRspWrap;
    logic        memReqValid;
    logic        memReqReady = 1'b0;
    logic [31:0] memReqAddr;
    logic        memRspValid = 1'b0;
    logic [31:0] memRspData = 32'd0;
    logic        invalidate = 1'b0;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    ifetch_cache #(.NUM_LINES(64), .WORDS_PER_LINE(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetchReqValid (fetchReqValid),
        .fetchReqReady (fetchReqReady),
        .fetchReqPc    (fetchReqPc),
        .fetchReqWrap  (fetchReqWrap),
        .fetchRspValid (fetchRspValid),
        .fetchRspInst  (fetchRspInst),
        .fetchRspPc    (fetchRspPc),
        .fetchRspWrap  (fetchRspWrap),
        .memReqValid   (memReqValid),
        .memReqReady   (memReqReady),
        .memReqAddr    (memReqAddr),
        .memRspValid   (memRspValid),
        .memRspData    (memRspData),
        .invalidate    (invalidate),
        .hitCount      (hitCount),
        .missCount     (missCount)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          mdl_valid [64];
    int unsigned mdl_tag [64];
    int unsigned mdl_hits = 0;
    int unsigned mdl_misses = 0;

    typedef struct {
        logic [31:0] pc;
        wrap_idx_t   wrap;
        bit          miss;
        logic [31:0] inst;
        int          stall;
    } vec_t;

    vec_t vecs [6];

    // Backing store contents: the 0x1000 line holds 0xA0..0xA3.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        base = a & 32'hFFFF_FFF0;
        if (base == 32'h0000_1000) return 32'hA0 + ((a - base) / 4);
        return (a ^ 32'hC0DE_0000) + 32'd7;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int unsigned idx;
        idx = (pc / 16) % 64;
        return mdl_valid[idx] && (mdl_tag[idx] == pc / 1024);
    endfunction

    task automatic model_fill(input logic [31:0] pc);
        mdl_valid[(pc / 16) % 64] = 1'b1;
        mdl_tag[(pc / 16) % 64]   = pc / 1024;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mdl_valid[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_counts(input string nm);
`ifdef ICACHE_STATS_EN
        check({nm, " hitCount"}, hitCount, mdl_hits);
        check({nm, " missCount"}, missCount, mdl_misses);
`else
        check({nm, " hitCount"}, hitCount, 32'd0);
        check({nm, " missCount"}, missCount, 32'd0);
`endif
    endtask

    task automatic check_idle(input string nm);
        check({nm, " ready"}, fetchReqReady, 32'd1);
        check({nm, " rspValid"}, fetchRspValid, 32'd0);
        check({nm, " rspInst"}, fetchRspInst, 32'd0);
        check({nm, " rspPc"}, fetchRspPc, 32'd0);
        check({nm, " rspWrap"}, 32'(fetchRspWrap), 32'd0);
        check({nm, " memReqValid"}, memReqValid, 32'd0);
        check({nm, " memReqAddr"}, memReqAddr, 32'd0);
    endtask

    // One request; on a miss, services the fill (with optional request stall
    // and an invalidate on the last beat) and checks the replayed response.
    task automatic run_fetch(input logic [31:0] pc, input wrap_idx_t wrap, input bit exp_miss,
                             input logic [31:0] exp_inst, input int stall, input bit inv_last,
                             input string nm);
        int          waited;
        logic [31:0] line;
        waited = 0;
        line = pc & 32'hFFFF_FFF0;
        while (!fetchReqReady && waited < 20) begin
            tick();
            waited++;
        end
        check({nm, " ready-before-req"}, fetchReqReady, 32'd1);
        fetchReqValid = 1'b1;
        fetchReqPc    = pc;
        fetchReqWrap  = wrap;
        tick();
        fetchReqValid = 1'b0;
        if (exp_miss) begin
            mdl_misses++;
            check({nm, " miss-ready"}, fetchReqReady, 32'd0);
            check({nm, " miss-norsp"}, fetchRspValid, 32'd0);
            check({nm, " miss-noreq-yet"}, memReqValid, 32'd0);
            for (int r = 0; r < (inv_last ? 2 : 1); r++) begin
                tick();
                for (int s = 0; s < ((r == 0) ? stall : 0); s++) begin
                    check({nm, " stall-reqValid"}, memReqValid, 32'd1);
                    check({nm, " stall-addr"}, memReqAddr, line);
                    check({nm, " stall-ready"}, fetchReqReady, 32'd0);
                    check({nm, " stall-norsp"}, fetchRspValid, 32'd0);
                    tick();
                end
                check({nm, " memReqValid"}, memReqValid, 32'd1);
                check({nm, " memReqAddr"}, memReqAddr, line);
                memReqReady = 1'b1;
                tick();
                memReqReady = 1'b0;
                check({nm, " req-dropped"}, memReqValid, 32'd0);
                for (int b = 0; b < 4; b++) begin
                    memRspValid = 1'b1;
                    memRspData  = mem_word(line + 32'(b * 4));
                    invalidate  = inv_last && (r == 0) && (b == 3);
                    tick();
                end
                memRspValid = 1'b0;
                invalidate  = 1'b0;
                check({nm, " replay-norsp"}, fetchRspValid, 32'd0);
                check({nm, " replay-ready"}, fetchReqReady, 32'd0);
                tick();
                if (inv_last && (r == 0)) begin
                    model_clear();
                    check({nm, " remiss-norsp"}, fetchRspValid, 32'd0);
                    check({nm, " remiss-ready"}, fetchReqReady, 32'd0);
                end
            end
            check({nm, " post-fill-ready"}, fetchReqReady, 32'd1);
        end else begin
            mdl_hits++;
        end
        check({nm, " rspValid"}, fetchRspValid, 32'd1);
        check({nm, " rspInst"}, fetchRspInst, exp_inst);
        check({nm, " rspPc"}, fetchRspPc, pc);
        check({nm, " rspWrap"}, 32'(fetchRspWrap), 32'(wrap));
        model_fill(pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] stream_pc [3];
        logic [31:0] pool [5];
        logic [31:0] pc;
        wrap_idx_t   wr;

        vecs[0] = '{32'h0000_1008, 2'd2, 1'b1, 32'h0000_00A2, 0};
        vecs[1] = '{32'h0000_1408, 2'd1, 1'b1, mem_word(32'h0000_1408), 0};
        vecs[2] = '{32'h0000_1008, 2'd3, 1'b1, 32'h0000_00A2, 0};
        vecs[3] = '{32'h0000_1004, 2'd0, 1'b0, 32'h0000_00A1, 0};
        vecs[4] = '{32'h0000_2040, 2'd1, 1'b1, mem_word(32'h0000_2040), 5};
        vecs[5] = '{32'h0000_2044, 2'd2, 1'b0, mem_word(32'h0000_2044), 0};
        stream_pc = '{32'h0000_1000, 32'h0000_1004, 32'h0000_100C};
        pool = '{32'h0000_1000, 32'h0000_1400, 32'h0000_1010, 32'h0000_2230, 32'h0000_6230};
        model_clear();

        tick();
        tick();
        check_idle("reset");
        check_counts("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_fetch(vecs[i].pc, vecs[i].wrap, vecs[i].miss, vecs[i].inst, vecs[i].stall,
                      1'b0, $sformatf("vec%0d", i));
            tick();
            check_counts($sformatf("vec%0d", i));
        end

        // Back-to-back hits: one response per cycle with ready held high.
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream%0d ready", i), fetchReqReady, 32'd1);
            fetchReqValid = 1'b1;
            fetchReqPc    = stream_pc[i];
            fetchReqWrap  = wrap_idx_t'(i);
            tick();
            check($sformatf("stream%0d rspValid", i), fetchRspValid, 32'd1);
            check($sformatf("stream%0d rspInst", i), fetchRspInst, mem_word(stream_pc[i]));
            check($sformatf("stream%0d rspPc", i), fetchRspPc, stream_pc[i]);
            mdl_hits++;
        end
        fetchReqValid = 1'b0;
        tick();
        check("stream end rspValid", fetchRspValid, 32'd0);
        check_counts("stream");

        // Stray fill beats while running must not touch the arrays.
        memRspValid = 1'b1;
        memRspData  = 32'hDEAD_BEEF;
        tick();
        tick();
        memRspValid = 1'b0;
        check("stray ready", fetchReqReady, 32'd1);
        check("stray memReqValid", memReqValid, 32'd0);
        run_fetch(32'h0000_1000, 2'd1, 1'b0, 32'h0000_00A0, 0, 1'b0, "stray-hit");
        tick();

        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        model_clear();
        run_fetch(32'h0000_1000, 2'd3, 1'b1, 32'h0000_00A0, 0, 1'b0, "inv-miss");
        tick();
        check_counts("inv");

        // Invalidate on the final fill beat: replay misses and refills.
        run_fetch(32'h0000_3010, 2'd0, 1'b1, mem_word(32'h0000_3010), 1, 1'b1, "inv-last");
        run_fetch(32'h0000_3018, 2'd1, 1'b0, mem_word(32'h0000_3018), 0, 1'b0, "inv-last-hit");
        tick();
        check_counts("inv-last");

        // Reset in the middle of a fill, after two beats.
        fetchReqValid = 1'b1;
        fetchReqPc    = 32'h0000_3450;
        fetchReqWrap  = 2'd2;
        tick();
        fetchReqValid = 1'b0;
        tick();
        check("rstfill memReqValid", memReqValid, 32'd1);
        memReqReady = 1'b1;
        tick();
        memReqReady = 1'b0;
        for (int b = 0; b < 2; b++) begin
            memRspValid = 1'b1;
            memRspData  = mem_word(32'h0000_3450 + 32'(b * 4));
            tick();
        end
        memRspValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        mdl_hits   = 0;
        mdl_misses = 0;
        check_idle("rstfill");
        check_counts("rstfill");
        run_fetch(32'h0000_3450, 2'd2, 1'b1, mem_word(32'h0000_3450), 0, 1'b0, "rstfill-miss");
        tick();

        for (int i = 0; i < 60; i++) begin
            pc = pool[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, 3));
            wr = wrap_idx_t'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                invalidate = 1'b1;
                tick();
                invalidate = 1'b0;
                model_clear();
            end
            run_fetch(pc, wr, !model_hit(pc), mem_word(pc), int'($urandom_range(0, 3)), 1'b0,
                      $sformatf("rnd%0d", i));
            tick();
            check_counts($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch_cache.md
# ifetch_cache

Direct-mapped instruction cache that responds to the fetch stage's per-wrap PC requests with instruction words. It sits between `fetch` and the core's memory port. Hits return one cycle after acceptance and are fully pipelined. Misses stall the request port, fill one line from memory in word beats, then replay the stalled request.

## Interface
Parameters:
- `NUM_LINES`, 64: lines in the cache; must be a power of two.
- `WORDS_PER_LINE`, 4: 32-bit words per line; must be a power of two, at least 2.

Ports:
- `clk`  in  1: core clock.
- `reset`  in  1: synchronous, active-high.
- `fetchReqValid`  in  1: fetch request present.
- `fetchReqReady`  out  1: request accepted when valid and ready are both high.
- `fetchReqPc`  in  32 (`scalar_t`): byte PC. Bits [1:0] must be 0.
- `fetchReqWrap`  in  `wrap_idx_t`: requesting wrap.
- `fetchRspValid`  out  1: single-cycle response pulse. There is no back-pressure; fetch always accepts it.
- `fetchRspInst`  out  32: instruction word.
- `fetchRspPc`  out  32: echoed PC.
- `fetchRspWrap`  out  `wrap_idx_t`: echoed wrap.
- `memReqValid`  out  1: line-fill request.
- `memReqReady`  in  1: memory accepts the request.
- `memReqAddr`  out  32: line-aligned byte address.
- `memRspValid`  in  1: one fill beat.
- `memRspData`  in  32: beat data. Beats arrive in ascending word order.
- `invalidate`  in  1: clears all valid bits.
- `hitCount`  out  32: hit counter (see Configuration).
- `missCount`  out  32: miss counter (see Configuration).

## Operation
- Address split:
  - offset = pc[2 +: log2(WORDS_PER_LINE)].
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
  - Defaults: offset pc[3:2], index pc[9:4], tag pc[31:10].
- Storage:
  - Valid bits are held in flops.
  - Tag and data arrays are synchronous-read SRAMs.
- Pipeline: request accept cycle (S0, arrays read) → S1 (tag compare, response).
- States:
  - RUN: accept and compare. `fetchReqReady` = !(s1Valid && !hit).
    - S1 hit: `fetchRspValid`=1 with data, pc and wrap.
    - S1 miss: hold S1, go to MISS_REQ.
  - MISS_REQ: `memReqValid`=1 with `memReqAddr` = {tag, index, 0}. Holds until `memReqReady`, then goes to MISS_FILL with the beat counter at 0.
  - MISS_FILL: each `memRspValid` writes word[beatCnt] of the data array. On the last beat (beatCnt = WORDS_PER_LINE-1), write the tag, set valid[index] and go to REPLAY.
  - REPLAY: re-read the arrays for the held S1 request, then go to RUN. S1 then hits and responds.
- `fetchReqReady`=0 in every state except RUN.
- `memRspValid` outside MISS_FILL is ignored.
- `invalidate`:
  - Clears all valid bits at the clock edge.
  - It beats a same-cycle fill tag write: that line stays invalid, and the replay misses again.
  - An S1 compare in the same cycle uses the pre-clear valid bits.
- Reset:
  - State = RUN, s1Valid=0, all valid bits cleared, counters 0.
  - A fill in progress is abandoned.
  - Outputs after reset: `fetchReqReady`=1; `fetchRspValid`=0; `memReqValid`=0; `memReqAddr`=0; `fetchRspInst`, `fetchRspPc`, `fetchRspWrap`=0; `hitCount`, `missCount`=0.

## Timing
- Hit: accepted in cycle N → `fetchRspValid` in N+1. Back-to-back hits sustain one per cycle.
- Miss: accepted in N.
  - N+1: miss detected, ready=0.
  - N+2: `memReqValid`=1.
  - Last fill beat in cycle L, then REPLAY in L+1.
  - Response with ready=1 in L+2.
- A new request may be accepted in the same cycle that a hit is responding.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hitCount` and `missCount` increment on each S1 hit or first-time S1 miss. Replay hits are not counted as hits.
  - Both counters saturate at 0xFFFFFFFF and are cleared by reset.
- `ICACHE_STATS_EN` undefined: both ports are tied to 0 and no counter logic is built.

## Structure
- `defines` package holds `scalar_t`, `NUM_WRAPS_PER_CORE`, `wrap_idx_t` (width $clog2(NUM_WRAPS_PER_CORE)) and the `icache_state_t` enum.
- Sub-module `sram_1r1w` (synchronous read, one write port) is instantiated twice: once for tags, once for data.
- Data array is NUM_LINES*WORDS_PER_LINE × 32.
- Write and read in the same cycle to the same address returns the old data. Sequencing never relies on bypass.

## Test plan
- Cold miss, default parameters:
  - Stimulus: pc 0x00001008, wrap 2. Memory accepts immediately and returns 0xA0,0xA1,0xA2,0xA3.
  - Required: `memReqAddr`=0x00001000; response 0xA2, pc 0x1008, wrap 2 two cycles after the last beat.
- Hit stream: after the fill, requests 0x1000, 0x1004, 0x100C on consecutive cycles → responses 0xA0, 0xA1, 0xA3 on consecutive cycles, ready held at 1.
- Conflict eviction: 0x00001408 (same index, new tag) misses and refills; then 0x1008 misses again. `missCount`=3 with stats enabled.
- Invalidate: `invalidate` pulsed, then 0x1000 → miss and new fill request. A `memRspValid` driven during RUN leaves the arrays unchanged.
- Stall: `memReqReady` held low for 5 cycles → `memReqValid` and address stable throughout, `fetchReqReady`=0, no response.
- Reset mid-fill, after 2 beats:
  - Required: state RUN, `memReqValid`=0, ready=1.
  - A following request to the same line misses.
